// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: combinational forwarding and stall/flush selects,
// a mul/div occupancy FSM in E, memory wait-state tracking in M, and a saturating stall counter.
module hazard_ctrl #(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  rs_e,
  input  logic [4:0]  rt_e,
  input  logic [4:0]  writereg_e,
  input  logic [4:0]  writereg_m,
  input  logic [4:0]  writereg_w,
  input  logic        regwrite_e,
  input  logic        regwrite_m,
  input  logic        regwrite_w,
  input  logic        memtoreg_e,
  input  logic        memtoreg_m,
  input  logic        memwrite_m,
  input  logic        branch_d,
  input  logic        mdstart_e,
  input  logic        mem_ready,
  output logic        forwarda_d,
  output logic        forwardb_d,
  output logic [1:0]  forwarda_e,
  output logic [1:0]  forwardb_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic        md_busy,
  output logic        md_done,
  output logic        mem_error,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);
  localparam logic [7:0] W_LAST  = 8'(MEM_TIMEOUT - 1);

  md_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] wcnt;
  logic       lwstall, branchstall, memstall, mdstall;

  assign lwstall     = memtoreg_e & ((rt_e == rs_d) | (rt_e == rt_d));
  assign branchstall = branch_d &
                       ((regwrite_e & ((writereg_e == rs_d) | (writereg_e == rt_d))) |
                        (memtoreg_m & ((writereg_m == rs_d) | (writereg_m == rt_d))));
  assign memstall    = (memtoreg_m | memwrite_m) & ~mem_ready;
  assign mdstall     = (state == BUSY);
  assign md_busy     = (state == BUSY);
  assign md_done     = (state == DONE);

  // Everything visible to the pipeline is forced quiet while reset is held.
  always_comb begin
    forwarda_e = 2'b00;
    forwardb_e = 2'b00;
    forwarda_d = 1'b0;
    forwardb_d = 1'b0;
    if (reset) begin
      if (regwrite_m && writereg_m != 5'd0 && writereg_m == rs_e)      forwarda_e = 2'b10;
      else if (regwrite_w && writereg_w != 5'd0 && writereg_w == rs_e) forwarda_e = 2'b01;
      if (regwrite_m && writereg_m != 5'd0 && writereg_m == rt_e)      forwardb_e = 2'b10;
      else if (regwrite_w && writereg_w != 5'd0 && writereg_w == rt_e) forwardb_e = 2'b01;
      forwarda_d = regwrite_m && writereg_m != 5'd0 && writereg_m == rs_d;
      forwardb_d = regwrite_m && writereg_m != 5'd0 && writereg_m == rt_d;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      if (memstall) begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end else if (mdstall) begin
        {stall_f, stall_d, stall_e} = 3'b111;
        flush_m = 1'b1;
      end else if (lwstall || branchstall) begin
        {stall_f, stall_d} = 2'b11;
        flush_e = 1'b1;
      end
    end
  end

  // DONE always returns to IDLE so the same mul/div instruction cannot retrigger.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (mdstart_e && !memstall) begin
        state_nxt = BUSY;
        cnt_nxt   = MD_LOAD;
      end
      BUSY: if (cnt == 4'd0) state_nxt = DONE;
            else             cnt_nxt   = cnt - 4'd1;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      wcnt         <= 8'd0;
      mem_error    <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (memstall) begin
        if (wcnt != W_LAST) wcnt <= wcnt + 8'd1;
        else                mem_error <= 1'b1;
      end else begin
        wcnt <= 8'd0;
      end
      if (stall_f && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipelined MIPS core.
- Generates forwarding selects and stall/flush enables for the F/D, D/E, E/M and M/W pipeline registers.
- Sequences a multi-cycle multiply/divide unit in E and data-memory wait states in M.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- MD_LATENCY, 4, cycles a mul/div occupies E; legal range 2..15.
- MEM_TIMEOUT, 64, consecutive not-ready cycles before mem_error sets; legal range 2..255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rs_d, rt_d  in  5  source regs in D.
- rs_e, rt_e  in  5  source regs in E.
- writereg_e, writereg_m, writereg_w  in  5  destination regs.
- regwrite_e, regwrite_m, regwrite_w  in  1  register write enables.
- memtoreg_e, memtoreg_m  in  1  load in E / M.
- memwrite_m  in  1  store in M.
- branch_d  in  1  branch in D.
- mdstart_e  in  1  mul/div instruction in E.
- mem_ready  in  1  data memory completes the access this cycle.
- forwarda_d, forwardb_d  out  1  D-stage comparator forward from M.
- forwarda_e, forwardb_e  out  2  E-stage ALU forward: 00 regfile, 01 W, 10 M.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the register.
- flush_e, flush_m, flush_w  out  1  insert a bubble.
- md_busy  out  1  mul/div FSM in BUSY.
- md_done  out  1  mul/div result valid this cycle.
- mem_error  out  1  sticky timeout flag.
- stall_cycles  out  32  saturating count of cycles with stall_f=1.

Behaviour:
Reset (reset=0, async):
- FSM to IDLE, counters 0, mem_error 0, stall_cycles 0.
- While reset=0, all stall/flush outputs are 0 and forwards are 00.

Forwarding (combinational):
- forwarda_e = 10 if regwrite_m, writereg_m≠0 and writereg_m==rs_e.
- Otherwise forwarda_e = 01 if regwrite_w, writereg_w≠0 and writereg_w==rs_e.
- Otherwise forwarda_e = 00. M has priority over W.
- forwardb_e: same rule using rt_e.
- forwarda_d = regwrite_m & writereg_m≠0 & writereg_m==rs_d. forwardb_d: same rule using rt_d.

Hazard terms:
- lwstall = memtoreg_e & (rt_e==rs_d | rt_e==rt_d).
- branchstall = branch_d & ((regwrite_e & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m∈{rs_d,rt_d})).
- memstall = (memtoreg_m | memwrite_m) & ~mem_ready.
- mdstall = state==BUSY.

Priority, highest first:
1. memstall: stall_f/d/e/m=1, flush_w=1, all other flushes 0.
2. mdstall: stall_f/d/e=1, flush_m=1.
3. lwstall|branchstall: stall_f/d=1, flush_e=1.
4. Otherwise all 0.

MD FSM (IDLE, BUSY, DONE):
- IDLE→BUSY when mdstart_e & ~memstall; load cnt=MD_LATENCY-2.
- BUSY: if cnt==0 go to DONE, else decrement cnt. BUSY lasts MD_LATENCY-1 cycles.
- DONE: md_done=1, no MD stall, E instruction advances; unconditional →IDLE. mdstart_e is ignored in DONE (same instruction).
- memstall arriving during BUSY: counting continues; memstall priority governs the outputs.
- md_busy=1 only in BUSY.

Memory timeout:
- wcnt increments each cycle memstall=1 and clears when memstall=0.
- When wcnt reaches MEM_TIMEOUT-1 while memstall=1, mem_error sets.
- wcnt saturates; mem_error clears only on reset.
- Stalling continues regardless of mem_error.

stall_cycles:
- Increments each cycle stall_f=1 and saturates at 0xFFFFFFFF.

Reset mid-operation:
- Asserting reset at any time returns the FSM to IDLE immediately and clears all counters.

Test Plan:
- regwrite_m=1, writereg_m=5, rs_e=5; regwrite_w=1, writereg_w=5 -> forwarda_e=10. With writereg_m=0 and rs_e=0 -> forwarda_e=00.
- memtoreg_e=1, rt_e=3, rs_d=3 -> stall_f=stall_d=flush_e=1 for that cycle; stall_cycles 0→1.
- MD_LATENCY=4, mdstart_e pulse held -> md_busy=1 for 3 cycles with stall_e=flush_m=1, then md_done=1 for one cycle, then IDLE with no retrigger.
- memtoreg_m=1, mem_ready=0 for 5 cycles while an lwstall condition is also present -> stall_f/d/e/m=1 and flush_w=1 each cycle, flush_e=0. With MEM_TIMEOUT=4, mem_error rises at the end of the 4th cycle and stays 1 after mem_ready=1.
- Drop reset to 0 during BUSY cycle 2 -> md_busy=0 immediately, stall_cycles=0, all stalls 0. After release, mdstart_e restarts a full 3-cycle BUSY.
- branch_d=1, regwrite_e=1, writereg_e=rt_d=7 -> stall_f=stall_d=flush_e=1. The same case with writereg_e=8 -> no stall.
